// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: datapath <-> hazard controller bundle.
// master = datapath (drives decode operand info and M/W taps, receives forward selects,
// stall/flush controls, FSM state and event counters); slave = hazard_ctrl_unit.
interface hazard_ctrl_if #(
  parameter int RA_W = 3,
  parameter int CNT_W = 16
);
  logic [RA_W-1:0] src1_d;
  logic src1_used_d;
  logic [RA_W-1:0] src2_d;
  logic src2_used_d;
  logic [RA_W-1:0] dst_d;
  logic wr_d;
  logic load_d;
  logic jump_d;
  logic branch_taken_e;
  logic [RA_W-1:0] wb2;
  logic wr_m;
  logic [RA_W-1:0] wb3;
  logic wr_w;
  logic [1:0] forward_a;
  logic [1:0] forward_b;
  logic stall;
  logic flush_d;
  logic flush_e;
  logic [1:0] pipe_state;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  modport master (
    output src1_d, src1_used_d, src2_d, src2_used_d, dst_d, wr_d, load_d, jump_d,
           branch_taken_e, wb2, wr_m, wb3, wr_w,
    input  forward_a, forward_b, stall, flush_d, flush_e, pipe_state, stall_count, flush_count
  );
  modport slave (
    input  src1_d, src1_used_d, src2_d, src2_used_d, dst_d, wr_d, load_d, jump_d,
           branch_taken_e, wb2, wr_m, wb3, wr_w,
    output forward_a, forward_b, stall, flush_d, flush_e, pipe_state, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: RAW stall, forwarding and branch/jump squash control for a 5-stage pipe.
// Ports: clk, rst (sync, active-high), hc (hazard_ctrl_if.slave): D-stage operands,
// M/W destination taps in; forward_a/b, stall, flush_d/e, pipe_state, saturating counters out.
module hazard_ctrl_unit #(
  parameter int RA_W = 3,
  parameter int CNT_W = 16,
  parameter bit R0_ZERO = 1'b1
) (
  input logic clk,
  input logic rst,
  hazard_ctrl_if.slave hc
);
  localparam logic [1:0] RUN = 2'b00;
  localparam logic [1:0] STALL = 2'b01;
  localparam logic [1:0] FLUSH = 2'b10;
  logic [RA_W-1:0] e_dst;
  logic e_wr, e_load, m_load;
  logic [1:0] state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic haz1, haz2, stall, jump_sq, flush_ev;
  function automatic logic match(input logic [RA_W-1:0] s, input logic u,
                                 input logic [RA_W-1:0] r, input logic w);
    return u & w & (s == r) & !(R0_ZERO && s == '0);
  endfunction
  // Load data is only usable from W, so an M-stage load never forwards from M.
  function automatic logic [1:0] fwd(input logic [RA_W-1:0] s, input logic u);
    return (match(s, u, hc.wb2, hc.wr_m) & !m_load) ? 2'b01 :
           match(s, u, hc.wb3, hc.wr_w) ? 2'b10 : 2'b00;
  endfunction
  // E producer always costs a cycle; a load still in M costs its second cycle.
  assign haz1 = match(hc.src1_d, hc.src1_used_d, e_dst, e_wr) |
                match(hc.src1_d, hc.src1_used_d, hc.wb2, hc.wr_m & m_load);
  assign haz2 = match(hc.src2_d, hc.src2_used_d, e_dst, e_wr) |
                match(hc.src2_d, hc.src2_used_d, hc.wb2, hc.wr_m & m_load);
  assign stall = (haz1 | haz2) & !hc.branch_taken_e;
  assign jump_sq = hc.jump_d & !stall;
  assign flush_ev = hc.branch_taken_e | jump_sq;
  assign hc.stall = stall;
  assign hc.flush_e = stall | hc.branch_taken_e;
  assign hc.flush_d = flush_ev;
  assign hc.forward_a = fwd(hc.src1_d, hc.src1_used_d);
  assign hc.forward_b = fwd(hc.src2_d, hc.src2_used_d);
  assign hc.pipe_state = state;
  assign hc.stall_count = stall_cnt;
  assign hc.flush_count = flush_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      e_dst <= '0;
      e_wr <= 1'b0;
      e_load <= 1'b0;
      m_load <= 1'b0;
      state <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      e_dst <= hc.flush_e ? '0 : hc.dst_d;
      e_wr <= hc.flush_e ? 1'b0 : hc.wr_d;
      e_load <= hc.flush_e ? 1'b0 : hc.load_d;
      m_load <= e_load;
      state <= flush_ev ? FLUSH : stall ? STALL : RUN;
      stall_cnt <= (stall && stall_cnt != '1) ? stall_cnt + CNT_W'(1) : stall_cnt;
      flush_cnt <= (flush_ev && flush_cnt != '1) ? flush_cnt + CNT_W'(1) : flush_cnt;
    end
  end
endmodule
